mailbox_fifo_unit: RTL and testbench

Parametrised successor to the single-word mailbox unit. Each of `NumMbox` channels holds a message FIFO of `Depth` entries instead of a single doorbell. Each channel has threshold-based receive interrupts, drain (send-done) interrupts and sticky overflow/underflow error flags. The block sits on the peripheral register bus as one slave with a 256-byte window per channel, and drives per-channel interrupt lines to the interrupt controller.

---
 rtl/mailbox_fifo_unit.sv | 184 ++++++++++++++++++
 tb/tb_mailbox_fifo_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mailbox_fifo_unit.sv
// Multi-channel mailbox: one message FIFO per channel with threshold, drain and
// error interrupts, exposed on the register bus as a 256-byte window per channel.
package mailbox_fifo_unit_pkg;
   typedef struct packed {
      logic        valid;
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } reg_req_t;

   typedef struct packed {
      logic        ready;
      logic [31:0] rdata;
      logic        error;
   } reg_rsp_t;
endpackage

module mailbox_fifo_unit #(
   parameter type reg_req_t = mailbox_fifo_unit_pkg::reg_req_t,
   parameter type reg_rsp_t = mailbox_fifo_unit_pkg::reg_rsp_t,
   parameter int  NumMbox   = 4,
   parameter int  Depth     = 8,
   parameter int  DataWidth = 32
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  reg_req_t           reg_req_i,
   output reg_rsp_t           reg_rsp_o,
   output logic [NumMbox-1:0] rcv_irq_o,
   output logic [NumMbox-1:0] snd_irq_o,
   output logic [NumMbox-1:0] err_irq_o
);
   localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int LvlW = $clog2(Depth + 1);
   localparam int ChW  = (NumMbox > 1) ? $clog2(NumMbox) : 1;
   localparam logic [LvlW-1:0] Full = LvlW'(Depth);

   localparam logic [7:0] OffPush   = 8'h00;
   localparam logic [7:0] OffPop    = 8'h04;
   localparam logic [7:0] OffPeek   = 8'h08;
   localparam logic [7:0] OffStatus = 8'h0C;
   localparam logic [7:0] OffThresh = 8'h10;
   localparam logic [7:0] OffIrqEn  = 8'h14;
   localparam logic [7:0] OffIrqSt  = 8'h18;
   localparam logic [7:0] OffFlush  = 8'h1C;

   if (NumMbox < 1 || NumMbox > 128) begin : g_bad_num_mbox
      $fatal(1, "mailbox_fifo_unit: NumMbox must be 1..128");
   end
   if (Depth < 2 || Depth > 256 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
      $fatal(1, "mailbox_fifo_unit: Depth must be a power of two in 2..256");
   end
   if (DataWidth < 1 || DataWidth > 32) begin : g_bad_width
      $fatal(1, "mailbox_fifo_unit: DataWidth must be 1..32");
   end

   logic [DataWidth-1:0] mem    [NumMbox][Depth];
   logic [PtrW-1:0]      rptr   [NumMbox];
   logic [PtrW-1:0]      wptr   [NumMbox];
   logic [LvlW-1:0]      level  [NumMbox];
   logic [8:0]           thresh [NumMbox];
   logic [2:0]           en     [NumMbox];
   logic [3:0]           stat   [NumMbox];

   logic [8:0]           thresh_nxt [NumMbox];
   logic [2:0]           en_nxt     [NumMbox];
   logic [3:0]           stat_nxt   [NumMbox];
   logic [NumMbox-1:0]   hit, push, pop, flush;

   logic [7:0]     ch, off;
   logic [ChW-1:0] idx;
   logic           ch_ok, off_ok, acc, wr, rd;
   logic [31:0]    rdata;
   logic           unused_bits;

   assign ch     = reg_req_i.addr[15:8];
   assign off    = reg_req_i.addr[7:0];
   assign idx    = ch[ChW-1:0];
   assign ch_ok  = 32'(ch) < NumMbox;
   assign off_ok = (off[1:0] == 2'b00) && (off <= OffFlush);
   assign acc    = reg_req_i.valid && ch_ok && off_ok && !rst_i;
   assign wr     = reg_req_i.write;
   assign rd     = !reg_req_i.write;

   assign unused_bits = ^{reg_req_i.addr[31:16], reg_req_i.wstrb[3:2]};

   // Per-channel next state; set conditions are OR-ed in last so they beat W1C.
   always_comb begin
      hit   = '0;
      push  = '0;
      pop   = '0;
      flush = '0;
      for (int i = 0; i < NumMbox; i++) begin
         thresh_nxt[i] = thresh[i];
         en_nxt[i]     = en[i];
         stat_nxt[i]   = stat[i];
         hit[i]   = acc && (ch == 8'(i));
         push[i]  = hit[i] && wr && (off == OffPush) && (level[i] != Full);
         pop[i]   = hit[i] && rd && (off == OffPop) && (level[i] != '0);
         flush[i] = hit[i] && wr && (off == OffFlush) && reg_req_i.wdata[0];
         if (hit[i] && wr && (off == OffThresh)) begin
            if (reg_req_i.wstrb[0]) thresh_nxt[i][7:0] = reg_req_i.wdata[7:0];
            if (reg_req_i.wstrb[1]) thresh_nxt[i][8]   = reg_req_i.wdata[8];
         end
         if (hit[i] && wr && (off == OffIrqEn) && reg_req_i.wstrb[0])
            en_nxt[i] = reg_req_i.wdata[2:0];
         if (hit[i] && wr && (off == OffIrqSt))
            stat_nxt[i] = stat[i] & ~reg_req_i.wdata[3:0];
         stat_nxt[i] = stat_nxt[i] | {
            hit[i] && rd && (off == OffPop) && (level[i] == '0),
            hit[i] && wr && (off == OffPush) && (level[i] == Full),
            pop[i] && (level[i] == LvlW'(1)),
            (thresh[i] != 9'd0) && (9'(level[i]) >= thresh[i])
         };
      end
   end

   // Read data is taken straight from current state; out-of-window accesses return 0.
   always_comb begin
      rdata = '0;
      if (acc && rd) begin
         case (off)
            OffPop, OffPeek: if (level[idx] != '0) rdata = 32'(mem[idx][rptr[idx]]);
            OffStatus: begin
               rdata[8:0] = 9'(level[idx]);
               rdata[16]  = (level[idx] == '0);
               rdata[17]  = (level[idx] == Full);
            end
            OffThresh: rdata[8:0] = thresh[idx];
            OffIrqEn:  rdata[2:0] = en[idx];
            OffIrqSt:  rdata[3:0] = stat[idx];
            default:   rdata = '0;
         endcase
      end
      reg_rsp_o       = '0;
      reg_rsp_o.ready = 1'b1;
      reg_rsp_o.rdata = rdata;
      reg_rsp_o.error = reg_req_i.valid && !rst_i && !(ch_ok && off_ok);
   end

   always_ff @(posedge clk_i) begin
      for (int i = 0; i < NumMbox; i++) begin
         if (push[i]) mem[i][wptr[i]] <= reg_req_i.wdata[DataWidth-1:0];
      end
   end

   // Interrupt lines are loaded from the next stat/en so they follow the flags with no extra lag.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NumMbox; i++) begin
            rptr[i]   <= '0;
            wptr[i]   <= '0;
            level[i]  <= '0;
            thresh[i] <= 9'd1;
            en[i]     <= '0;
            stat[i]   <= '0;
         end
         rcv_irq_o <= '0;
         snd_irq_o <= '0;
         err_irq_o <= '0;
      end else begin
         for (int i = 0; i < NumMbox; i++) begin
            if (flush[i]) begin
               rptr[i]  <= '0;
               wptr[i]  <= '0;
               level[i] <= '0;
            end else if (push[i]) begin
               wptr[i]  <= wptr[i] + 1'b1;
               level[i] <= level[i] + 1'b1;
            end else if (pop[i]) begin
               rptr[i]  <= rptr[i] + 1'b1;
               level[i] <= level[i] - 1'b1;
            end
            thresh[i]    <= thresh_nxt[i];
            en[i]        <= en_nxt[i];
            stat[i]      <= stat_nxt[i];
            rcv_irq_o[i] <= stat_nxt[i][0] & en_nxt[i][0];
            snd_irq_o[i] <= stat_nxt[i][1] & en_nxt[i][1];
            err_irq_o[i] <= (stat_nxt[i][2] | stat_nxt[i][3]) & en_nxt[i][2];
         end
      end
   end
endmodule

// File: tb/tb_mailbox_fifo_unit.sv
// Bench for mailbox_fifo_unit: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized bus traffic.
module tb_mailbox_fifo_unit;
   import mailbox_fifo_unit_pkg::*;

   localparam int NumMbox = 4;
   localparam int Depth   = 8;

   logic clock = 1'b0;
   logic reset = 1'b1;
   reg_req_t req;
   reg_rsp_t rsp;
   logic [NumMbox-1:0] rcvIrq, sndIrq, errIrq;

   int total = 0;
   int bad   = 0;
   bit modelLive = 1'b0;

   logic [31:0] mq      [NumMbox][$];
   logic [8:0]  mThresh [NumMbox];
   logic [2:0]  mEn     [NumMbox];
   logic [3:0]  mStat   [NumMbox];

   logic [31:0] lastRdata;
   logic        lastErr;

   mailbox_fifo_unit #(.NumMbox(NumMbox), .Depth(Depth), .DataWidth(32)) dut (
      .clk_i     (clock),
      .rst_i     (reset),
      .reg_req_i (req),
      .reg_rsp_o (rsp),
      .rcv_irq_o (rcvIrq),
      .snd_irq_o (sndIrq),
      .err_irq_o (errIrq)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic bit inWindow(input logic [31:0] a);
      return (int'(a[15:8]) < NumMbox) && (a[1:0] == 2'b00) && (a[7:0] <= 8'h1C);
   endfunction

   // Expected bus response for the request currently on the bus.
   function automatic void expectRsp(output logic [31:0] rd, output logic er);
      int ch;
      int sz;
      rd = '0;
      er = 1'b0;
      if (reset || !req.valid) return;
      if (!inWindow(req.addr)) begin
         er = 1'b1;
         return;
      end
      ch = int'(req.addr[15:8]);
      sz = mq[ch].size();
      if (!req.write) begin
         case (req.addr[7:0])
            8'h04, 8'h08: rd = (sz > 0) ? mq[ch][0] : 32'h0;
            8'h0C: rd = 32'(sz) | ((sz == 0) ? 32'h1_0000 : 32'h0) | ((sz == Depth) ? 32'h2_0000 : 32'h0);
            8'h10: rd = 32'(mThresh[ch]);
            8'h14: rd = 32'(mEn[ch]);
            8'h18: rd = 32'(mStat[ch]);
            default: rd = 32'h0;
         endcase
      end
   endfunction

   // Advance the model across one rising edge using the request that was on the bus.
   task automatic modelEdge();
      bit setRcv [NumMbox];
      int ch;
      if (reset) begin
         for (int i = 0; i < NumMbox; i++) begin
            mq[i].delete();
            mThresh[i] = 9'd1;
            mEn[i]     = 3'd0;
            mStat[i]   = 4'd0;
         end
         modelLive = 1'b1;
         return;
      end
      for (int i = 0; i < NumMbox; i++)
         setRcv[i] = (mThresh[i] != 0) && (mq[i].size() >= int'(mThresh[i]));
      if (req.valid && inWindow(req.addr)) begin
         ch = int'(req.addr[15:8]);
         if (req.write) begin
            case (req.addr[7:0])
               8'h00: if (mq[ch].size() == Depth) mStat[ch][2] = 1'b1;
                      else mq[ch].push_back(req.wdata);
               8'h10: begin
                  if (req.wstrb[0]) mThresh[ch][7:0] = req.wdata[7:0];
                  if (req.wstrb[1]) mThresh[ch][8]   = req.wdata[8];
               end
               8'h14: if (req.wstrb[0]) mEn[ch] = req.wdata[2:0];
               8'h18: mStat[ch] = mStat[ch] & ~req.wdata[3:0];
               8'h1C: if (req.wdata[0]) mq[ch].delete();
               default: ;
            endcase
         end else if (req.addr[7:0] == 8'h04) begin
            if (mq[ch].size() == 0) mStat[ch][3] = 1'b1;
            else begin
               if (mq[ch].size() == 1) mStat[ch][1] = 1'b1;
               void'(mq[ch].pop_front());
            end
         end
      end
      for (int i = 0; i < NumMbox; i++)
         if (setRcv[i]) mStat[i][0] = 1'b1;
   endtask

   // Single compare process: bus response and interrupt lines against the model.
   always @(negedge clock) begin
      logic [31:0] er;
      logic ee;
      logic [NumMbox-1:0] expR, expS, expE;
      if (modelLive) begin
         expectRsp(er, ee);
         checkOutput("rsp_rdata", rsp.rdata, er);
         checkOutput("rsp_error", 32'(rsp.error), 32'(ee));
         checkOutput("rsp_ready", 32'(rsp.ready), 32'd1);
         for (int i = 0; i < NumMbox; i++) begin
            expR[i] = mStat[i][0] & mEn[i][0];
            expS[i] = mStat[i][1] & mEn[i][1];
            expE[i] = (mStat[i][2] | mStat[i][3]) & mEn[i][2];
         end
         checkOutput("rcv_irq", 32'(rcvIrq), 32'(expR));
         checkOutput("snd_irq", 32'(sndIrq), 32'(expS));
         checkOutput("err_irq", 32'(errIrq), 32'(expE));
      end
   end

   task automatic applyStimulus(input logic v, input logic w, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] s);
      req.valid = v;
      req.write = w;
      req.addr  = a;
      req.wdata = d;
      req.wstrb = s;
      @(negedge clock);
      lastRdata = rsp.rdata;
      lastErr   = rsp.error;
      @(posedge clock);
      modelEdge();
      #1;
   endtask

   task automatic wrReg(input int ch, input logic [7:0] off, input logic [31:0] d);
      applyStimulus(1'b1, 1'b1, {16'h0, 8'(ch), off}, d, 4'hF);
   endtask

   task automatic rdReg(input int ch, input logic [7:0] off);
      applyStimulus(1'b1, 1'b0, {16'h0, 8'(ch), off}, 32'h0, 4'h0);
   endtask

   task automatic doReset();
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      reset = 1'b0;
   endtask

   initial begin
      logic [31:0] vals [3];
      int ch, pick;
      logic [7:0] off;
      logic w;
      logic [31:0] d;
      logic [3:0] s;

      req = '0;
      doReset();

      // Reset state.
      rdReg(0, 8'h0C);
      checkOutput("reset_status", lastRdata, 32'h0001_0000);
      checkOutput("reset_irqs", 32'({rcvIrq, sndIrq, errIrq}), 32'h0);

      // Threshold interrupt on channel 1.
      wrReg(1, 8'h14, 32'h1);
      wrReg(1, 8'h10, 32'h3);
      wrReg(1, 8'h00, 32'hA);
      wrReg(1, 8'h00, 32'hB);
      wrReg(1, 8'h00, 32'hC);
      checkOutput("rcv_irq_not_yet", 32'(rcvIrq[1]), 32'h0);
      rdReg(1, 8'h04);
      checkOutput("pop_a", lastRdata, 32'hA);
      checkOutput("rcv_irq_rise", 32'(rcvIrq[1]), 32'h1);
      rdReg(1, 8'h04);
      checkOutput("pop_b", lastRdata, 32'hB);
      rdReg(1, 8'h04);
      checkOutput("pop_c", lastRdata, 32'hC);
      wrReg(1, 8'h18, 32'h1);
      checkOutput("rcv_irq_fall", 32'(rcvIrq[1]), 32'h0);

      // Overflow and underflow on channel 2.
      for (int k = 0; k < 9; k++) wrReg(2, 8'h00, 32'h20 + 32'(k));
      rdReg(2, 8'h0C);
      checkOutput("full_status", lastRdata, 32'h0002_0008);
      rdReg(2, 8'h18);
      checkOutput("ovf_stat", lastRdata, 32'h5);
      for (int k = 0; k < 8; k++) begin
         rdReg(2, 8'h04);
         checkOutput("pop_order", lastRdata, 32'h20 + 32'(k));
      end
      rdReg(2, 8'h04);
      checkOutput("pop_empty_data", lastRdata, 32'h0);
      checkOutput("pop_empty_err", 32'(lastErr), 32'h0);
      rdReg(2, 8'h18);
      checkOutput("unf_stat", lastRdata, 32'hF);

      // Pointer wrap-around with drain interrupt on channel 0.
      wrReg(0, 8'h14, 32'h2);
      for (int r = 0; r < 5; r++) begin
         for (int j = 0; j < 3; j++) begin
            vals[j] = $urandom;
            wrReg(0, 8'h00, vals[j]);
         end
         for (int j = 0; j < 3; j++) begin
            rdReg(0, 8'h04);
            checkOutput("wrap_data", lastRdata, vals[j]);
         end
         checkOutput("snd_after_drain", 32'(sndIrq[0]), 32'h1);
         wrReg(0, 8'h18, 32'h2);
         checkOutput("snd_cleared", 32'(sndIrq[0]), 32'h0);
      end
      rdReg(0, 8'h0C);
      checkOutput("wrap_final_status", lastRdata, 32'h0001_0000);

      // Out-of-window accesses.
      rdReg(NumMbox, 8'h0C);
      checkOutput("bad_ch_err", 32'(lastErr), 32'h1);
      checkOutput("bad_ch_rdata", lastRdata, 32'h0);
      wrReg(NumMbox, 8'h00, 32'h55);
      checkOutput("bad_ch_push_err", 32'(lastErr), 32'h1);
      rdReg(0, 8'h20);
      checkOutput("bad_off_err", 32'(lastErr), 32'h1);
      wrReg(0, 8'h20, 32'hFFFF_FFFF);
      rdReg(0, 8'h0C);
      checkOutput("no_side_effect", lastRdata, 32'h0001_0000);

      // Reset mid-traffic.
      wrReg(3, 8'h14, 32'h7);
      for (int k = 0; k < 5; k++) wrReg(3, 8'h00, 32'h300 + 32'(k));
      wrReg(2, 8'h14, 32'h4);
      checkOutput("pre_reset_rcv", 32'(rcvIrq[3]), 32'h1);
      checkOutput("pre_reset_err", 32'(errIrq[2]), 32'h1);
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      reset = 1'b0;
      checkOutput("post_reset_irqs", 32'({rcvIrq, sndIrq, errIrq}), 32'h0);
      rdReg(3, 8'h0C);
      checkOutput("post_reset_status", lastRdata, 32'h0001_0000);
      rdReg(3, 8'h10);
      checkOutput("post_reset_thresh", lastRdata, 32'h1);

      // Randomized traffic; the compare process checks every cycle.
      for (int n = 0; n < 800; n++) begin
         ch   = $urandom_range(0, NumMbox);
         pick = $urandom_range(0, 15);
         w    = 1'b0;
         d    = $urandom;
         s    = 4'($urandom_range(0, 15));
         case (pick)
            0, 1, 2, 3: begin off = 8'h00; w = 1'b1; end
            4, 5, 6, 7: off = 8'h04;
            8:  off = 8'h08;
            9:  off = 8'h0C;
            10: begin off = 8'h10; w = 1'($urandom_range(0, 1)); d = 32'($urandom_range(0, 9)); end
            11: begin off = 8'h14; w = 1'($urandom_range(0, 1)); end
            12: begin off = 8'h18; w = 1'($urandom_range(0, 1)); end
            13: begin off = 8'h1C; w = 1'b1; end
            14: begin off = 8'h20; w = 1'($urandom_range(0, 1)); end
            default: begin off = 8'h06; w = 1'($urandom_range(0, 1)); end
         endcase
         reset = ($urandom_range(0, 99) == 0);
         applyStimulus(1'($urandom_range(0, 7) != 0), w, {16'h0, 8'(ch), off}, d, s);
         reset = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
